mult_sched: RTL and testbench

- Shares one pipelined multiplier (the pipe_mult datapath, fixed latency LAT from en to done) between NREQ requesters.
- Arbitrates requests round-robin and issues at most one operation per cycle.
- Tracks the requester id and tag of each in-flight operation in order, and buffers products in a result FIFO with a ready/valid output.
- Credit accounting guarantees that no product returned by the multiplier is ever dropped.

---
 rtl/mult_sched_pkg.sv | 22 ++
 rtl/mult_fifo.sv | 57 +++++
 rtl/mult_sched.sv | 169 ++++++++++++++++
 tb/tb_mult_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared widths and record formats for the multiplier scheduler
package mult_sched_pkg;

   localparam int MS_DATA_WIDTH = 32;
   localparam int MS_TAG_WIDTH  = 4;
   localparam int MS_NREQ       = 2;
   localparam int MS_LAT        = 8;
   localparam int MS_RES_DEPTH  = 16;
   localparam int MS_ID_WIDTH   = (MS_NREQ > 1) ? $clog2(MS_NREQ) : 1;

   typedef struct packed {
      logic [MS_ID_WIDTH-1:0]  id;
      logic [MS_TAG_WIDTH-1:0] tag;
   } mult_tag_t;

   typedef struct packed {
      logic [MS_ID_WIDTH-1:0]   id;
      logic [MS_TAG_WIDTH-1:0]  tag;
      logic [MS_DATA_WIDTH-1:0] data;
   } mult_rsp_t;

endpackage

// File: rtl/mult_fifo.sv
// rtl/mult_fifo.sv - register-based synchronous FIFO with push/pop/full/empty/count
module mult_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign do_pop   = pop && !empty;
   // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - round-robin scheduler sharing one pipelined multiplier between requesters
module mult_sched
   import mult_sched_pkg::*;
#(
   parameter int DATA_WIDTH = MS_DATA_WIDTH,
   parameter int LAT        = MS_LAT,
   parameter int NREQ       = MS_NREQ,
   parameter int TAG_WIDTH  = MS_TAG_WIDTH,
   parameter int RES_DEPTH  = MS_RES_DEPTH,
   localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW        = $clog2(RES_DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid_i,
   output logic [NREQ-1:0]           req_ready_o,
   input  logic [NREQ*DATA_WIDTH-1:0] req_a_i,
   input  logic [NREQ*DATA_WIDTH-1:0] req_b_i,
   input  logic [NREQ*TAG_WIDTH-1:0] req_tag_i,
   output logic                      mul_rst_o,
   output logic                      mul_en_o,
   output logic [DATA_WIDTH-1:0]     mul_a_o,
   output logic [DATA_WIDTH-1:0]     mul_b_o,
   input  logic [DATA_WIDTH-1:0]     mul_prod_i,
   input  logic                      mul_done_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [IDW-1:0]            rsp_id_o,
   output logic [TAG_WIDTH-1:0]      rsp_tag_o,
   output logic [DATA_WIDTH-1:0]     rsp_data_o,
   output logic                      spurious_o
);

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] gnt_id;
   logic           gnt_found;
   int             rr_idx;
   logic [CW-1:0]  credits;
   logic           can_issue;
   logic           accept;
   logic           rsp_pop;

   mult_tag_t      tag_push;
   mult_tag_t      tag_head;
   logic           tag_pop;
   logic           tag_full;
   logic           tag_empty;
   logic [CW-1:0]  tag_count;

   mult_rsp_t      res_push_data;
   mult_rsp_t      res_head;
   logic           res_push;
   logic           res_full;
   logic           res_empty;
   logic [CW-1:0]  res_count;

   // Credits cover every op between accept and response pop, so the result FIFO can never overflow.
   assign can_issue = (credits < CW'(RES_DEPTH)) && !mul_rst_o;

   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      rr_idx    = 0;
      for (int i = 0; i < NREQ; i++) begin
         rr_idx = (int'(rr_ptr) + i) % NREQ;
         if (!gnt_found && req_valid_i[rr_idx]) begin
            gnt_found = 1'b1;
            gnt_id    = IDW'(rr_idx);
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (can_issue && gnt_found) begin
         req_ready_o[gnt_id] = 1'b1;
      end
   end

   assign accept  = can_issue && gnt_found;
   assign rsp_pop = rsp_valid_o && rsp_ready_i;
   assign tag_pop = mul_done_i && !tag_empty;
   assign res_push = tag_pop;

   always_comb begin
      tag_push.id  = gnt_id;
      tag_push.tag = req_tag_i[gnt_id*TAG_WIDTH +: TAG_WIDTH];
   end

   always_comb begin
      res_push_data.id   = tag_head.id;
      res_push_data.tag  = tag_head.tag;
      res_push_data.data = mul_prod_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_rst_o  <= 1'b1;
         mul_en_o   <= 1'b0;
         mul_a_o    <= '0;
         mul_b_o    <= '0;
         rr_ptr     <= '0;
         credits    <= '0;
         spurious_o <= 1'b0;
      end else begin
         mul_rst_o <= 1'b0;
         mul_en_o  <= accept;
         if (accept) begin
            mul_a_o <= req_a_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            mul_b_o <= req_b_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr  <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
         end
         if (accept && !rsp_pop) begin
            credits <= credits + 1'b1;
         end else if (rsp_pop && !accept) begin
            credits <= credits - 1'b1;
         end
         if (mul_done_i && tag_empty) begin
            spurious_o <= 1'b1;
         end
      end
   end

   mult_fifo #(
      .WIDTH ($bits(mult_tag_t)),
      .DEPTH (RES_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .push_data (tag_push),
      .pop       (tag_pop),
      .pop_data  (tag_head),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (tag_count)
   );

   mult_fifo #(
      .WIDTH ($bits(mult_rsp_t)),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (res_push),
      .push_data (res_push_data),
      .pop       (rsp_pop),
      .pop_data  (res_head),
      .full      (res_full),
      .empty     (res_empty),
      .count     (res_count)
   );

   assign rsp_valid_o = !res_empty;
   assign rsp_id_o    = res_head.id;
   assign rsp_tag_o   = res_head.tag;
   assign rsp_data_o  = res_head.data;

   // Ops in flight are bounded by the multiplier depth plus the issue register.
   a_tag_bound: assert property (@(posedge clk) disable iff (!rst_n)
      tag_count <= CW'(LAT + 1));
   a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(accept && tag_full && !tag_pop));
   a_res_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(res_push && res_full && !rsp_pop));
   a_res_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      res_count <= credits);

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - directed self-checking bench for mult_sched with a LAT-cycle multiplier model
module tb_mult_sched;

   localparam int DW  = 32;
   localparam int TW  = 4;
   localparam int NR  = 2;
   localparam int LAT = 8;
   localparam int RD  = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NR-1:0]   req_valid_i = '0;
   logic [NR-1:0]   req_ready_o;
   logic [NR*DW-1:0] req_a_i = '0;
   logic [NR*DW-1:0] req_b_i = '0;
   logic [NR*TW-1:0] req_tag_i = '0;
   logic            mul_rst_o;
   logic            mul_en_o;
   logic [DW-1:0]   mul_a_o;
   logic [DW-1:0]   mul_b_o;
   logic [DW-1:0]   mul_prod_i;
   logic            mul_done_i;
   logic            rsp_valid_o;
   logic            rsp_ready_i = 1'b0;
   logic            rsp_id_o;
   logic [TW-1:0]   rsp_tag_o;
   logic [DW-1:0]   rsp_data_o;
   logic            spurious_o;
   logic            force_done = 1'b0;

   int tests = 0;
   int fails = 0;
   logic [1+TW+DW-1:0] exp_q [$];
   int n_acc [NR];

   always #5 clk = ~clk;

   logic [LAT-1:0] pv;
   logic [DW-1:0]  pp [LAT];
   always @(posedge clk) begin
      if (mul_rst_o) begin
         pv <= '0;
      end else begin
         pv    <= {pv[LAT-2:0], mul_en_o};
         pp[0] <= mul_a_o * mul_b_o;
         for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
      end
   end
   assign mul_done_i = pv[LAT-1] | force_done;
   assign mul_prod_i = pp[LAT-1];

   mult_sched #(.DATA_WIDTH(DW), .LAT(LAT), .NREQ(NR), .TAG_WIDTH(TW), .RES_DEPTH(RD)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
      .mul_rst_o(mul_rst_o), .mul_en_o(mul_en_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
      .mul_prod_i(mul_prod_i), .mul_done_i(mul_done_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
      .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o), .spurious_o(spurious_o)
   );

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid_i = '0;
      rsp_ready_i = 1'b0;
      force_done = 1'b0;
      exp_q.delete();
      for (int r = 0; r < NR; r++) n_acc[r] = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic drive_payload();
      for (int r = 0; r < NR; r++) begin
         req_a_i[r*DW +: DW]   = 32'h100 * (r + 1) + 32'(n_acc[r]);
         req_b_i[r*DW +: DW]   = 32'(n_acc[r] + 3 + r);
         req_tag_i[r*TW +: TW] = TW'(n_acc[r] * 2 + r);
      end
   endtask

   task automatic note_accepts(output int got);
      logic [DW-1:0] p;
      got = 0;
      for (int r = 0; r < NR; r++) begin
         if (req_ready_o[r] && req_valid_i[r]) begin
            p = req_a_i[r*DW +: DW] * req_b_i[r*DW +: DW];
            exp_q.push_back({1'(r), req_tag_i[r*TW +: TW], p});
            n_acc[r]++;
            got++;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      req_valid_i = 2'b11;
      #1;
      tests++;
      if ({mul_rst_o, mul_en_o, mul_a_o, mul_b_o} !== {1'b1, 1'b0, 64'h0}) begin
         fails++; $display("FAIL reset_mul got rst=%b en=%b a=%h b=%h", mul_rst_o, mul_en_o, mul_a_o, mul_b_o);
      end
      tests++;
      if ({rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o, spurious_o, req_ready_o} !== '0) begin
         fails++; $display("FAIL reset_rsp got v=%b id=%b tag=%h data=%h sp=%b rdy=%b, want all 0",
                           rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o, spurious_o, req_ready_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++;
      if (mul_rst_o !== 1'b1 || req_ready_o !== 2'b00) begin
         fails++; $display("FAIL release_hold got mul_rst=%b rdy=%b want 1/00", mul_rst_o, req_ready_o);
      end
      @(negedge clk);
      #1;
      tests++;
      if (mul_rst_o !== 1'b0 || req_ready_o !== 2'b01) begin
         fails++; $display("FAIL first_grant got mul_rst=%b rdy=%b want 0/01", mul_rst_o, req_ready_o);
      end
      req_valid_i = '0;
   endtask

   task automatic test_single();
      apply_reset();
      req_valid_i = 2'b01;
      req_a_i[0 +: DW] = 32'd3;
      req_b_i[0 +: DW] = 32'd7;
      req_tag_i[0 +: TW] = 4'd5;
      #1;
      tests++;
      if (req_ready_o !== 2'b01) begin
         fails++; $display("FAIL single_ready got %b want 01", req_ready_o);
      end
      @(negedge clk);
      req_valid_i = '0;
      tests++;
      if (mul_en_o !== 1'b1 || mul_a_o !== 32'd3 || mul_b_o !== 32'd7) begin
         fails++; $display("FAIL single_issue got en=%b a=%0d b=%0d want 1/3/7", mul_en_o, mul_a_o, mul_b_o);
      end
      for (int c = 2; c <= 9; c++) begin
         @(negedge clk);
         tests++;
         if (rsp_valid_o !== 1'b0 || mul_en_o !== 1'b0) begin
            fails++; $display("FAIL single_early cycle %0d got v=%b en=%b want 0/0", c, rsp_valid_o, mul_en_o);
         end
      end
      @(negedge clk);
      tests++;
      if ({rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o} !== {1'b1, 1'b0, 4'd5, 32'd21}) begin
         fails++; $display("FAIL single_rsp got v=%b id=%0d tag=%0d data=%0d want 1/0/5/21",
                           rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      tests++;
      if (rsp_valid_o !== 1'b0) begin
         fails++; $display("FAIL single_pop got v=%b want 0", rsp_valid_o);
      end
   endtask

   task automatic test_contention();
      int got;
      int exp_g = 0;
      logic [1+TW+DW-1:0] e;
      apply_reset();
      rsp_ready_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         req_valid_i = 2'b11;
         drive_payload();
         #1;
         tests++;
         if (req_ready_o !== (2'b01 << exp_g)) begin
            fails++; $display("FAIL contention_grant cycle %0d got %b want %b", c, req_ready_o, 2'b01 << exp_g);
         end
         if (c > 0) begin
            tests++;
            if (mul_en_o !== 1'b1) begin
               fails++; $display("FAIL contention_en cycle %0d got %b want 1", c, mul_en_o);
            end
         end
         if (rsp_valid_o) begin
            e = exp_q.pop_front();
            tests++;
            if ({rsp_id_o, rsp_tag_o, rsp_data_o} !== e) begin
               fails++; $display("FAIL contention_rsp got %h want %h", {rsp_id_o, rsp_tag_o, rsp_data_o}, e);
            end
         end
         note_accepts(got);
         exp_g = 1 - exp_g;
      end
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         req_valid_i = '0;
         #1;
         if (rsp_valid_o) begin
            e = exp_q.pop_front();
            tests++;
            if ({rsp_id_o, rsp_tag_o, rsp_data_o} !== e) begin
               fails++; $display("FAIL contention_rsp got %h want %h", {rsp_id_o, rsp_tag_o, rsp_data_o}, e);
            end
         end
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL contention_drain got %0d outstanding want 0", exp_q.size());
      end
      req_valid_i = '0;
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      int got;
      int total = 0;
      logic [1+TW+DW-1:0] e;
      apply_reset();
      for (int c = 0; c < 30; c++) begin
         if (c > 0) @(negedge clk);
         req_valid_i = 2'b11;
         drive_payload();
         #1;
         note_accepts(got);
         total += got;
      end
      tests++;
      if (total != 16 || req_ready_o !== 2'b00) begin
         fails++; $display("FAIL bp_fill got %0d accepts rdy=%b want 16/00", total, req_ready_o);
      end
      tests++;
      if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_tag_o, rsp_data_o} !== exp_q[0]) begin
         fails++; $display("FAIL bp_head got v=%b %h want 1 %h", rsp_valid_o, {rsp_id_o, rsp_tag_o, rsp_data_o}, exp_q[0]);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid_i = '0;
         rsp_ready_i = 1'b1;
         #1;
         e = exp_q.pop_front();
         tests++;
         if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_tag_o, rsp_data_o} !== e) begin
            fails++; $display("FAIL bp_pop got v=%b %h want 1 %h", rsp_valid_o, {rsp_id_o, rsp_tag_o, rsp_data_o}, e);
         end
      end
      total = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         rsp_ready_i = 1'b0;
         req_valid_i = 2'b11;
         drive_payload();
         #1;
         note_accepts(got);
         total += got;
      end
      tests++;
      if (total != 5) begin
         fails++; $display("FAIL bp_refill got %0d accepts want 5", total);
      end
      for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         req_valid_i = '0;
         rsp_ready_i = 1'b1;
         #1;
         if (rsp_valid_o) begin
            e = exp_q.pop_front();
            tests++;
            if ({rsp_id_o, rsp_tag_o, rsp_data_o} !== e) begin
               fails++; $display("FAIL bp_drain got %h want %h", {rsp_id_o, rsp_tag_o, rsp_data_o}, e);
            end
         end
      end
      @(negedge clk);
      tests++;
      if (exp_q.size() != 0 || rsp_valid_o !== 1'b0) begin
         fails++; $display("FAIL bp_lost got %0d outstanding v=%b want 0/0", exp_q.size(), rsp_valid_o);
      end
      req_valid_i = '0;
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_wrap();
      int pops = 0;
      apply_reset();
      req_valid_i = 2'b11;
      req_a_i = {32'h0001_0000, 32'hFFFF_FFFF};
      req_b_i = {32'h0001_0000, 32'hFFFF_FFFF};
      req_tag_i = {4'd2, 4'd1};
      @(negedge clk);
      req_valid_i = 2'b10;
      @(negedge clk);
      req_valid_i = 2'b00;
      rsp_ready_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_valid_o) begin
            tests++;
            if (pops == 0 && {rsp_id_o, rsp_tag_o, rsp_data_o} !== {1'b0, 4'd1, 32'h0000_0001}) begin
               fails++; $display("FAIL wrap_ones got id=%0d tag=%0d data=%h want 0/1/00000001", rsp_id_o, rsp_tag_o, rsp_data_o);
            end
            if (pops == 1 && {rsp_id_o, rsp_tag_o, rsp_data_o} !== {1'b1, 4'd2, 32'h0}) begin
               fails++; $display("FAIL wrap_zero got id=%0d tag=%0d data=%h want 1/2/00000000", rsp_id_o, rsp_tag_o, rsp_data_o);
            end
            pops++;
         end
      end
      tests++;
      if (pops != 2) begin
         fails++; $display("FAIL wrap_count got %0d responses want 2", pops);
      end
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_midflight_reset();
      apply_reset();
      rsp_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         req_valid_i = 2'b01;
         req_a_i[0 +: DW] = 32'(c + 2);
         req_b_i[0 +: DW] = 32'(c + 5);
      end
      @(negedge clk);
      req_valid_i = '0;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({mul_rst_o, mul_en_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_data_o, spurious_o} !== {1'b1, 99'h0}) begin
         fails++; $display("FAIL midreset_out got rst=%b en=%b a=%h b=%h v=%b sp=%b want 1/0/0/0/0/0",
                           mul_rst_o, mul_en_o, mul_a_o, mul_b_o, rsp_valid_o, spurious_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++;
      if (mul_rst_o !== 1'b1) begin
         fails++; $display("FAIL midreset_hold got mul_rst=%b want 1", mul_rst_o);
      end
      @(negedge clk);
      tests++;
      if (mul_rst_o !== 1'b0) begin
         fails++; $display("FAIL midreset_release got mul_rst=%b want 0", mul_rst_o);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         tests++;
         if (rsp_valid_o !== 1'b0 || spurious_o !== 1'b0) begin
            fails++; $display("FAIL midreset_quiet cycle %0d got v=%b sp=%b want 0/0", c, rsp_valid_o, spurious_o);
         end
      end
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_spurious();
      apply_reset();
      tests++;
      if (spurious_o !== 1'b0) begin
         fails++; $display("FAIL spurious_idle got %b want 0", spurious_o);
      end
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      tests++;
      if (spurious_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         fails++; $display("FAIL spurious_set got sp=%b v=%b want 1/0", spurious_o, rsp_valid_o);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (spurious_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         fails++; $display("FAIL spurious_sticky got sp=%b v=%b want 1/0", spurious_o, rsp_valid_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_wrap();
      test_midflight_reset();
      test_spurious();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
